// File: rtl/ws2812_cmd_loader.sv
// ws2812_cmd_loader
// Turns a byte stream of 4-byte packets {index, c1, c2, c3} into single-cycle
// write commands for a WS2812 LED driver. Bad indices and stalled packets are
// dropped with a one-cycle err pulse while byte framing is preserved.
//
// Optional feature: define WS2812_CMD_FILL_EN to make index 0xFF a broadcast
// that writes the same colour to every LED on consecutive cycles.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   rx_data/valid/ready byte input handshake (transfer when valid & ready)
//   rgb_data, led_num   colour word {c1,c2,c3} and LED index for the driver
//   write               one-cycle write strobe
//   busy                packet partially received or fill running
//   err                 one-cycle pulse when a packet is dropped
//
// State table:
//   IDLE | waiting for index byte
//   B1   | index held, waiting for colour byte 1
//   B2   | waiting for colour byte 2
//   B3   | waiting for colour byte 3
//   FILL | broadcasting colour to all LEDs (WS2812_CMD_FILL_EN only)
module ws2812_cmd_loader #(
    parameter int NUM_LEDS   = 8,
    parameter int CLK_MHZ    = 12,
    parameter int TIMEOUT_US = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        write,
    output logic        busy,
    output logic        err
);

    localparam int              LIMIT    = CLK_MHZ * TIMEOUT_US;
    localparam int              CW       = $clog2(LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT_M1 = CW'(LIMIT - 1);
    localparam logic [8:0]      NUM_C    = 9'(NUM_LEDS);
`ifdef WS2812_CMD_FILL_EN
    localparam int              FW       = $clog2(NUM_LEDS + 1);
    localparam logic [FW-1:0]   NUM_F    = FW'(NUM_LEDS);
`endif

    typedef enum logic [2:0] {
        IDLE,
        B1,
        B2,
        B3
`ifdef WS2812_CMD_FILL_EN
        , FILL
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    idx_q, idx_d;
    logic [15:0]   col_q, col_d;
    logic [23:0]   rgb_q, rgb_d;
    logic [7:0]    led_q, led_d;
    logic          write_q, write_d;
    logic          err_q, err_d;
    // Keeps rx_ready low until the first clock edge after reset releases.
    logic          init_q;
`ifdef WS2812_CMD_FILL_EN
    logic [FW-1:0] fill_q, fill_d;
`endif

    logic accept;
    logic idx_ok;

`ifdef WS2812_CMD_FILL_EN
    assign rx_ready = init_q && (state_q != FILL);
`else
    assign rx_ready = init_q;
`endif
    assign accept   = rx_valid && rx_ready;
    assign idx_ok   = ({1'b0, idx_q} < NUM_C);
    assign busy     = (state_q != IDLE);
    assign write    = write_q;
    assign err      = err_q;
    assign rgb_data = rgb_q;
    assign led_num  = led_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        col_d   = col_q;
        rgb_d   = rgb_q;
        led_d   = led_q;
        write_d = 1'b0;
        err_d   = 1'b0;
`ifdef WS2812_CMD_FILL_EN
        fill_d  = fill_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    idx_d   = rx_data;
                    state_d = B1;
                end
            end
            B1, B2, B3: begin
                // An accepted byte wins over a timeout in the same cycle.
                if (accept) begin
                    cnt_d = '0;
                    if (state_q == B1) begin
                        col_d[15:8] = rx_data;
                        state_d     = B2;
                    end else if (state_q == B2) begin
                        col_d[7:0] = rx_data;
                        state_d    = B3;
                    end else begin
                        state_d = IDLE;
`ifdef WS2812_CMD_FILL_EN
                        if (idx_q == 8'hFF) begin
                            rgb_d   = {col_q, rx_data};
                            led_d   = 8'd0;
                            write_d = 1'b1;
                            fill_d  = FW'(1);
                            state_d = FILL;
                        end else
`endif
                        if (idx_ok) begin
                            rgb_d   = {col_q, rx_data};
                            led_d   = idx_q;
                            write_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else if (cnt_q == LIMIT_M1) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef WS2812_CMD_FILL_EN
            // LED 0 was already issued on entry; fill_q is the next LED.
            FILL: begin
                if (fill_q == NUM_F) begin
                    state_d = IDLE;
                end else begin
                    write_d = 1'b1;
                    led_d   = 8'(fill_q);
                    fill_d  = fill_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            col_q   <= '0;
            rgb_q   <= '0;
            led_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            init_q  <= 1'b0;
`ifdef WS2812_CMD_FILL_EN
            fill_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            rgb_q   <= rgb_d;
            led_q   <= led_d;
            write_q <= write_d;
            err_q   <= err_d;
            init_q  <= 1'b1;
`ifdef WS2812_CMD_FILL_EN
            fill_q  <= fill_d;
`endif
        end
    end

endmodule
